// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: reset address, the canonical NOP,
// RV32I major opcodes and the types used inside the fetch unit.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // RV32I major opcodes (inst[6:0]) shared by fetch and decode
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // BOOT is the one idle cycle after reset; RUN fetches continuously
  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

  // One buffered instruction together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, inst} between instruction memory and decode.
// Flush empties it in one cycle; a push into a full buffer is an
// upstream bug and is trapped by an assertion.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  fetch_entry_t slots [DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         full;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  // Occupancy flags and guarded push/pop so pointers never run past each other
  always_comb begin
    full    = (count == FULL_COUNT);
    empty   = (count == 2'd0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer and count bookkeeping; reset and flush both empty the buffer
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage, cleared on reset so stale words never reappear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (do_push && !flush) begin
      slots[wr_ptr] <= wr_entry;
    end
  end

  // The oldest entry is always the one under the read pointer
  always_comb begin
    head = slots[rd_ptr];
  end

  // Writing a full buffer without a simultaneous pop means the issue logic is broken
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues sequential word reads to instruction
// memory, buffers up to two returned words with their PCs and hands
// them to decode. A downstream redirect flushes everything in flight
// and restarts fetching at the new target on the following cycle.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = inst_fetch_pkg::RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  import inst_fetch_pkg::*;

  localparam logic [31:0] BOOT_PC   = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [2:0]  BUF_LIMIT = 3'(BUF_DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         run;

  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         inflight;
  logic         drop;

  logic [31:0]  redirect_target;
  logic [2:0]   occupancy;
  logic         pop;
  logic         push;
  logic         issue;
  logic         buf_empty;

  fetch_entry_t wr_entry;
  fetch_entry_t head;
  logic [1:0]   count;

  // State register: reset parks the unit in BOOT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: BOOT lasts exactly one cycle, RUN is permanent until reset
  always_comb begin
    state_next = state;
    case (state)
      FETCH_BOOT: state_next = FETCH_RUN;
      FETCH_RUN:  state_next = FETCH_RUN;
      default:    state_next = FETCH_BOOT;
    endcase
  end

  // FSM output: requests are only allowed once running
  always_comb begin
    run = (state == FETCH_RUN);
  end

  // Handshake decisions; redirect and reset override every pop, push and issue
  always_comb begin
    redirect_target = align_word(redirect_pc);
    buf_empty       = (count == 2'd0);
    inst_valid      = !rst && !buf_empty && !redirect;
    pop             = inst_valid && id_ready;
    push            = inflight && !drop && !redirect && !rst;
    occupancy       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue           = run && !rst && !redirect && (occupancy < BUF_LIMIT);
    wr_entry.pc     = req_pc;
    wr_entry.inst   = imem_rdata;
  end

  // Memory-side and decode-side outputs; reset forces the documented idle values
  always_comb begin
    imem_req  = issue;
    imem_addr = rst ? BOOT_PC : fetch_pc;
    if (rst) begin
      inst    = 32'h0;
      inst_pc = 32'h0;
    end else if (buf_empty) begin
      inst    = NOP;
      inst_pc = fetch_pc;
    end else begin
      inst    = head.inst;
      inst_pc = head.pc;
    end
  end

  // Fetch PC, inflight tracking and the drop flag for a squashed response
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= BOOT_PC;
      req_pc   <= BOOT_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= issue;
      drop     <= redirect && inflight;
      if (issue) begin
        req_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_target;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

endmodule
